// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: sync, data-enable, coordinates and strobes.
// Timing runs only while the synchronized PLL lock is high and restarts at (0,0) on each lock.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 10
) (
    input  logic          refclk,
    input  logic          rst_n,
    input  logic          pll_locked,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          running
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic          lock_meta_q, lock_s_q;
    logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CW-1:0] h_cur, v_cur;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic          running_q, running_d;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d       = lock_s_q ? RUN : IDLE;
        // Leaving IDLE always decodes (0,0), independent of what the counters hold.
        h_cur         = (state_q == RUN) ? h_cnt_q : '0;
        v_cur         = (state_q == RUN) ? v_cnt_q : '0;
        h_cnt_d       = '0;
        v_cnt_d       = '0;
        hsync_d       = ~HS_POL;
        vsync_d       = ~VS_POL;
        de_d          = 1'b0;
        x_d           = '0;
        y_d           = '0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        running_d     = 1'b0;
        if (lock_s_q) begin
            if (h_cur == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cur == V_LAST) ? '0 : v_cur + CW'(1);
            end else begin
                h_cnt_d = h_cur + CW'(1);
                v_cnt_d = v_cur;
            end
            x_d           = h_cur;
            y_d           = v_cur;
            de_d          = (h_cur < H_ACT) && (v_cur < V_ACT);
            hsync_d       = ((h_cur >= HS_BEG) && (h_cur < HS_END)) ? HS_POL : ~HS_POL;
            vsync_d       = ((v_cur >= VS_BEG) && (v_cur < VS_END)) ? VS_POL : ~VS_POL;
            line_start_d  = (h_cur == '0);
            frame_start_d = (h_cur == '0) && (v_cur == '0);
            running_d     = 1'b1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster (25 x 11) so full frames fit in a short run.
// A position-count model is compared every cycle; directed measurements pin the raster figures.
module tb_vga_timing_gen;
    localparam int unsigned HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int unsigned VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int unsigned CW = 10;
    localparam int unsigned HT = HA + HF + HS + HB;  // 25
    localparam int unsigned VT = VA + VF + VS + VB;  // 11

    typedef logic [25:0] vec_t;  // {hsync,vsync,de,running,line_start,frame_start,x,y}
    localparam vec_t RESET_V = 26'h300_0000;

    logic          refclk = 1'b0;
    logic          rst_n = 1'b1;
    logic          pll_locked = 1'b0;
    logic          hsync, vsync, de, line_start, frame_start, running;
    logic [CW-1:0] x, y;
    int            checks = 0;
    int            failures = 0;
    bit            chk_en = 1'b0;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start), .running(running)
    );

    always #5 refclk = ~refclk;

    vec_t act;
    assign act = {hsync, vsync, de, running, line_start, frame_start, x, y};

    // Expected outputs for the k-th cycle of a run, straight from raster arithmetic.
    function automatic vec_t decode(input bit run, input int unsigned k);
        int unsigned h, v;
        if (!run) return RESET_V;
        h = k % HT;
        v = (k / HT) % VT;
        return {!(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS),
                (h < HA && v < VA), 1'b1, (h == 0), (h == 0 && v == 0), 10'(h), 10'(v)};
    endfunction

    logic        s1, s2;
    int unsigned run_k;
    vec_t        exp_v;

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            run_k <= 0;
            exp_v <= RESET_V;
        end else begin
            s1    <= pll_locked;
            s2    <= s1;
            exp_v <= decode(s2, run_k);
            run_k <= s2 ? run_k + 1 : 0;
        end
    end

    always @(negedge refclk) begin
        if (chk_en) begin
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, a, e);
        end
    endtask

    // Counts posedges until frame_start is seen (sampled 1 time unit after each edge).
    task automatic edges_to_frame(output int n);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge refclk); #1;
            n++;
            if (frame_start) break;
        end
    endtask

    task automatic wait_xy(input int wx, input int wy, output bit found);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge refclk); #1;
            if (x == CW'(wx) && y == CW'(wy) && running) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int n, c, period, line_gap, de_cnt, de_line0, hs_cnt, hs_first, vs_cnt, vs_first;
        int maxx, maxy;
        bit found;

        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        #1 check("reset_outputs", act, RESET_V);
        repeat (3) @(posedge refclk);
        #2 rst_n = 1'b1;
        repeat (100) @(posedge refclk);
        #1 check("idle_outputs", act, RESET_V);

        // Lock acquisition.
        #1 pll_locked = 1'b1;
        edges_to_frame(n);
        check("lock_latency", n, 3);
        check("acq_x", x, 0);
        check("acq_y", y, 0);
        check("acq_de", de, 1);
        check("acq_running", running, 1);

        // Measure one frame starting at this frame_start (cycle c=0).
        period = 0; line_gap = 0; de_cnt = 0; de_line0 = 0;
        hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first = -1; maxx = 0; maxy = 0;
        for (c = 0; c < 1000; c++) begin
            if (c > 0) begin
                @(posedge refclk); #1;
            end
            if (c > 0 && frame_start) begin
                period = c;
                break;
            end
            if (c > 0 && line_start && line_gap == 0) line_gap = c;
            if (de) begin
                de_cnt++;
                if (c < int'(HT)) de_line0++;
                if (int'(x) > maxx) maxx = int'(x);
                if (int'(y) > maxy) maxy = int'(y);
            end
            if (!hsync && c < int'(HT)) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = c;
            end
            if (!vsync) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = c;
            end
        end
        check("frame_period", period, 275);
        check("line_period", line_gap, 25);
        check("de_per_line", de_line0, 16);
        check("de_per_frame", de_cnt, 96);
        check("hsync_width", hs_cnt, 4);
        check("hsync_offset", hs_first, 18);
        check("vsync_width", vs_cnt, 50);
        check("vsync_offset", vs_first, 175);
        check("last_active_x", maxx, 15);
        check("last_active_y", maxy, 5);

        // Lock loss mid-frame.
        wait_xy(10, 3, found);
        check("wait_loss_point", found, 1);
        #1 pll_locked = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge refclk); #1;
            n++;
            if (!running) break;
        end
        check("loss_latency", n, 3);
        check("loss_outputs", act, RESET_V);
        repeat (5) @(posedge refclk);
        #1 check("loss_idle", act, RESET_V);
        #1 pll_locked = 1'b1;
        edges_to_frame(n);
        check("relock_latency", n, 3);
        check("relock_y", y, 0);
        check("relock_x", x, 0);

        // Async reset pulse between edges.
        wait_xy(5, 0, found);
        check("wait_reset_point", found, 1);
        #1 rst_n = 1'b0;
        #1 check("async_reset_outputs", act, RESET_V);
        rst_n = 1'b1;
        edges_to_frame(n);
        check("post_reset_latency", n, 3);
        check("post_reset_y", y, 0);
        repeat (300) @(posedge refclk);
        #1 chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
